inst_mem_pipe: RTL and testbench
================================

Name: inst_mem_pipe

Overview:
Parametrised, pipelined instruction memory that replaces the combinational instruction ROM. It is loaded at run time through a write port. Fetches use a valid/ready request channel and return through a valid/ready response channel with configurable latency. Responses carry alignment and range error flags, and a flush input discards in-flight fetches on redirect. It sits between the IF stage and the instruction store.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 32, byte-address width
DEPTH_LOG2, 10, log2 of word count; array holds 2^DEPTH_LOG2 words
LATENCY, 2, request-accept to response-valid cycles; legal range 1..4
BASE_ADDR, 32'h0000_0100, byte address mapped to word 0

Ports:
CLK  in  1  clock
RST  in  1  reset
CEN  in  1  fetch enable; 0 blocks new requests
REQ_VALID  in  1  fetch request valid
REQ_READY  out  1  fetch request accepted when VALID&READY
REQ_ADDR  in  ADDR_W  fetch byte address
RSP_VALID  out  1  response valid
RSP_READY  in  1  consumer accepts response
RSP_INST  out  DATA_W  fetched instruction
RSP_ERR_ALIGN  out  1  request address not word aligned
RSP_ERR_RANGE  out  1  request address outside mapped window
FLUSH  in  1  discard all in-flight fetches
LD_VALID  in  1  load-port write strobe
LD_ADDR  in  DEPTH_LOG2  load word index
LD_DATA  in  DATA_W  load data

Behaviour:
- One clock, CLK. RST is asynchronous and active-high.
- Reset values: RSP_VALID=0, RSP_INST=0, both error flags 0, all pipeline valid bits 0. The array is not cleared by RST and its contents survive reset.
- Pipeline: LATENCY stages, each holding valid, inst, err_align and err_range. Stage LATENCY-1 drives the RSP_* ports.
- advance = !(RSP_VALID && !RSP_READY). When advance=0, every stage holds.
- REQ_READY = CEN && advance && !LD_VALID. This is combinational; the load port has priority over fetches.
- Array read is synchronous and occurs on the accept edge. Pipeline data is 0 when the matching valid is 0.
- Address translation: off = REQ_ADDR - BASE_ADDR, computed in ADDR_W bits with wrap.
  - err_align = REQ_ADDR[1:0] != 0.
  - err_range = (REQ_ADDR < BASE_ADDR) || (off[ADDR_W-1:2] >= 2^DEPTH_LOG2).
  - Word index = off[DEPTH_LOG2+1:2].
  - Either error: inst forced to 0 (NOP) and the array is not read. Both flags may be set together.
- Response timing: with no backpressure, a request accepted at edge N gives RSP_VALID=1 after edge N+LATENCY-1, so the response is visible in the cycle following that edge.
- Throughput is 1 fetch per cycle. Responses return in order.
- A response is consumed when RSP_VALID && RSP_READY.
- Backpressure: while RSP_VALID && !RSP_READY, RSP_* are stable and REQ_READY=0.
- FLUSH: on the edge with FLUSH=1, all stage valid bits clear, including the output stage, regardless of RSP_READY.
  - A request accepted in the same cycle as FLUSH is not discarded; it enters stage 0 as the redirect target.
  - FLUSH during backpressure also frees the stall on the next cycle.
- Load port: on an edge with LD_VALID=1, mem[LD_ADDR] <= LD_DATA.
  - Fetches already in flight return the old data.
  - A fetch accepted on a later cycle returns the new data.
- CEN=0 only blocks acceptance; in-flight fetches drain normally.
- RST mid-operation: in-flight responses are lost, with no spurious RSP_VALID after reset release.
- LATENCY outside 1..4 is a fatal elaboration error.

Test Plan:
- Load words 0..3 with 0x2401_0001..0x2401_0004, then fetch 0x100, 0x104, 0x108, 0x10C back-to-back with LATENCY=2 and RSP_READY=1 -> four consecutive RSP_VALID cycles carrying those words in order, first response 2 cycles after first accept, no errors.
- Fetch 0x102 -> RSP_INST=0, RSP_ERR_ALIGN=1. Fetch 0x0FC -> ERR_RANGE=1. With DEPTH_LOG2=10, fetch 0x1100 -> ERR_RANGE=1. Fetch 0x10FC -> valid word 1023.
- Hold RSP_READY=0 for 3 cycles with 2 fetches in flight -> RSP_INST stable and REQ_READY=0 throughout; after release, both responses arrive in order with none lost or duplicated.
- Fetch 0x100 and 0x104, then assert FLUSH together with a request at 0x10C -> only the 0x10C response appears.
- Assert LD_VALID to word 5 while REQ_VALID=1 -> REQ_READY=0 that cycle. The next fetch of 0x114 returns the new data; a fetch of 0x114 accepted before the load returns the old data.
- Assert RST with 2 fetches in flight -> RSP_VALID drops immediately (asynchronously) with no response after release. A fetch of 0x100 after release returns the pre-reset contents.

Source files
------------

// File: rtl/inst_mem_pipe.sv
// Pipelined, run-time loadable instruction memory with valid/ready fetch and response channels.
// Responses carry alignment/range error flags; FLUSH discards in-flight fetches on redirect.
module inst_mem_pipe #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter int                LATENCY    = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0100
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [ADDR_W-1:0]     REQ_ADDR,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_W-1:0]     RSP_INST,
  output logic                  RSP_ERR_ALIGN,
  output logic                  RSP_ERR_RANGE,
  input  logic                  FLUSH,
  input  logic                  LD_VALID,
  input  logic [DEPTH_LOG2-1:0] LD_ADDR,
  input  logic [DATA_W-1:0]     LD_DATA
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $fatal(1, "inst_mem_pipe: LATENCY must be in 1..4");
  end

  // Word 0 sits at BASE_ADDR, so the base itself has to be word aligned.
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $fatal(1, "inst_mem_pipe: BASE_ADDR must be word aligned");
  end

  localparam int LAST = LATENCY - 1;

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];

  logic [ADDR_W-3:0]     off_word;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  err_align;
  logic                  err_range;
  logic                  advance;
  logic                  accept;

  logic [LATENCY-1:0]    valid_q, valid_d;
  logic [LATENCY-1:0]    align_q, align_d;
  logic [LATENCY-1:0]    range_q, range_d;
  logic [DATA_W-1:0]     inst_q [LATENCY];
  logic [DATA_W-1:0]     inst_d [LATENCY];

  // With an aligned base, the word part of (REQ_ADDR - BASE_ADDR) never borrows from the low bits.
  assign off_word  = REQ_ADDR[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
  assign word_idx  = off_word[DEPTH_LOG2-1:0];
  assign err_align = |REQ_ADDR[1:0];
  assign err_range = (REQ_ADDR < BASE_ADDR) || (|off_word[ADDR_W-3:DEPTH_LOG2]);

  assign advance   = !(valid_q[LAST] && !RSP_READY);
  assign REQ_READY = CEN && advance && !LD_VALID;
  assign accept    = REQ_VALID && REQ_READY;

  always_comb begin
    valid_d = valid_q;
    align_d = align_q;
    range_d = range_q;
    for (int i = 0; i < LATENCY; i++) begin
      inst_d[i] = inst_q[i];
    end

    if (FLUSH) begin
      valid_d = '0;
      align_d = '0;
      range_d = '0;
      for (int i = 0; i < LATENCY; i++) begin
        inst_d[i] = '0;
      end
    end else if (advance) begin
      for (int i = 1; i < LATENCY; i++) begin
        valid_d[i] = valid_q[i-1];
        align_d[i] = align_q[i-1];
        range_d[i] = range_q[i-1];
        inst_d[i]  = inst_q[i-1];
      end
    end

    // A fetch accepted alongside FLUSH is the redirect target and must survive it.
    if (advance) begin
      valid_d[0] = accept;
      align_d[0] = accept && err_align;
      range_d[0] = accept && err_range;
      inst_d[0]  = (accept && !err_align && !err_range) ? mem[word_idx] : '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      align_q <= '0;
      range_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        inst_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      align_q <= align_d;
      range_q <= range_d;
      for (int i = 0; i < LATENCY; i++) begin
        inst_q[i] <= inst_d[i];
      end
    end
  end

  // The array is deliberately outside the reset domain so loaded code survives RST.
  always_ff @(posedge CLK) begin
    if (LD_VALID) begin
      mem[LD_ADDR] <= LD_DATA;
    end
  end

  assign RSP_VALID     = valid_q[LAST];
  assign RSP_INST      = inst_q[LAST];
  assign RSP_ERR_ALIGN = align_q[LAST];
  assign RSP_ERR_RANGE = range_q[LAST];

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Scoreboard bench for inst_mem_pipe: directed fetches push expected responses,
// an independent monitor pops and compares every consumed response.
module tb_inst_mem_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CEN;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [31:0] REQ_ADDR;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_INST;
  logic        RSP_ERR_ALIGN;
  logic        RSP_ERR_RANGE;
  logic        FLUSH;
  logic        LD_VALID;
  logic [9:0]  LD_ADDR;
  logic [31:0] LD_DATA;

  typedef struct packed {
    logic [31:0] inst;
    logic        ea;
    logic        er;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   total = 0;
  int   bad   = 0;

  inst_mem_pipe #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h0000_0100)
  ) dut (
    .CLK(CLK), .RST(RST), .CEN(CEN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_INST(RSP_INST),
    .RSP_ERR_ALIGN(RSP_ERR_ALIGN), .RSP_ERR_RANGE(RSP_ERR_RANGE),
    .FLUSH(FLUSH), .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // A response presented while FLUSH is high is discarded by the redirect, not consumed.
  always @(negedge CLK) begin
    if (RST === 1'b0 && RSP_VALID && RSP_READY && !FLUSH) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL spuriousRsp: got inst %h expected no response", RSP_INST);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("rspInst", RSP_INST, monExp.inst);
        checkOutput("rspErrAlign", 32'(RSP_ERR_ALIGN), 32'(monExp.ea));
        checkOutput("rspErrRange", 32'(RSP_ERR_RANGE), 32'(monExp.er));
      end
    end
  end

  // Holds the request until accepted, then records the hand-computed response.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expInst,
                               input logic expA, input logic expR);
    bit accepted = 1'b0;
    REQ_VALID = 1'b1;
    REQ_ADDR  = addr;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge CLK);
      if (REQ_READY) accepted = 1'b1;
      @(posedge CLK);
    end
    if (accepted) begin
      expQ.push_back('{inst: expInst, ea: expA, er: expR});
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL acceptTimeout: got no accept for %h expected accept", addr);
    end
    #1;
  endtask

  task automatic loadWord(input logic [9:0] idx, input logic [31:0] data);
    LD_VALID = 1'b1;
    LD_ADDR  = idx;
    LD_DATA  = data;
    @(posedge CLK);
    #1;
    LD_VALID = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int k = 0;
    while (expQ.size() != 0 && k < 40) begin
      @(posedge CLK);
      #2;
      k++;
    end
    checkOutput(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1; CEN = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; RSP_READY = 1'b1;
    FLUSH = 1'b0; LD_VALID = 1'b0; LD_ADDR = '0; LD_DATA = '0;

    @(negedge CLK);
    checkOutput("resetRspValid", 32'(RSP_VALID), 32'd0);
    checkOutput("resetRspInst", RSP_INST, 32'd0);
    checkOutput("resetErrAlign", 32'(RSP_ERR_ALIGN), 32'd0);
    checkOutput("resetErrRange", 32'(RSP_ERR_RANGE), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    for (int i = 0; i < 4; i++) begin
      loadWord(10'(i), 32'h2401_0001 + 32'(i));
    end
    loadWord(10'd5, 32'h2401_0006);
    loadWord(10'd1023, 32'h2401_03FF);

    $display("[TB] back-to-back fetch stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h100 + 32'(4 * i), 32'h2401_0001 + 32'(i), 1'b0, 1'b0);
      if (i == 0) checkOutput("latencyNotEarly", 32'(RSP_VALID), 32'd0);
      else        checkOutput("streamValid", 32'(RSP_VALID), 32'd1);
    end
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    checkOutput("streamValidLast", 32'(RSP_VALID), 32'd1);
    @(posedge CLK); #1;
    checkOutput("streamEnd", 32'(RSP_VALID), 32'd0);
    waitDrain("streamDrain");

    $display("[TB] address error cases");
    applyStimulus(32'h0000_0102, 32'h0, 1'b1, 1'b0);
    applyStimulus(32'h0000_00FC, 32'h0, 1'b0, 1'b1);
    applyStimulus(32'h0000_1100, 32'h0, 1'b0, 1'b1);
    applyStimulus(32'h0000_10FC, 32'h2401_03FF, 1'b0, 1'b0);
    applyStimulus(32'h0000_00FE, 32'h0, 1'b1, 1'b1);
    REQ_VALID = 1'b0;
    waitDrain("errorDrain");

    CEN = 1'b0; REQ_VALID = 1'b1; REQ_ADDR = 32'h100;
    @(negedge CLK);
    checkOutput("cenBlocks", 32'(REQ_READY), 32'd0);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; CEN = 1'b1;

    $display("[TB] backpressure");
    RSP_READY = 1'b0;
    applyStimulus(32'h104, 32'h2401_0002, 1'b0, 1'b0);
    applyStimulus(32'h108, 32'h2401_0003, 1'b0, 1'b0);
    REQ_VALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checkOutput("stallValid", 32'(RSP_VALID), 32'd1);
      checkOutput("stallInst", RSP_INST, 32'h2401_0002);
      checkOutput("stallReqReady", 32'(REQ_READY), 32'd0);
    end
    @(posedge CLK); #1;
    RSP_READY = 1'b1;
    waitDrain("stallDrain");

    $display("[TB] flush with redirect");
    applyStimulus(32'h100, 32'h2401_0001, 1'b0, 1'b0);
    applyStimulus(32'h104, 32'h2401_0002, 1'b0, 1'b0);
    FLUSH = 1'b1; REQ_VALID = 1'b1; REQ_ADDR = 32'h10C;
    @(negedge CLK);
    checkOutput("flushReqReady", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    expQ.delete();
    if (REQ_READY) expQ.push_back('{inst: 32'h2401_0004, ea: 1'b0, er: 1'b0});
    #1;
    FLUSH = 1'b0; REQ_VALID = 1'b0;
    waitDrain("flushDrain");

    $display("[TB] load port vs in-flight fetch");
    applyStimulus(32'h114, 32'h2401_0006, 1'b0, 1'b0);
    LD_VALID = 1'b1; LD_ADDR = 10'd5; LD_DATA = 32'hCAFE_0005;
    REQ_VALID = 1'b1; REQ_ADDR = 32'h114;
    @(negedge CLK);
    checkOutput("loadBlocksReq", 32'(REQ_READY), 32'd0);
    @(posedge CLK); #1;
    LD_VALID = 1'b0;
    applyStimulus(32'h114, 32'hCAFE_0005, 1'b0, 1'b0);
    REQ_VALID = 1'b0;
    waitDrain("loadDrain");

    $display("[TB] reset mid-operation");
    applyStimulus(32'h108, 32'h2401_0003, 1'b0, 1'b0);
    applyStimulus(32'h10C, 32'h2401_0004, 1'b0, 1'b0);
    REQ_VALID = 1'b0;
    checkOutput("preResetValid", 32'(RSP_VALID), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("asyncResetValid", 32'(RSP_VALID), 32'd0);
    expQ.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("noSpuriousAfterReset", 32'(RSP_VALID), 32'd0);
    applyStimulus(32'h100, 32'h2401_0001, 1'b0, 1'b0);
    REQ_VALID = 1'b0;
    waitDrain("postResetDrain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
